// File: rtl/inventory_ctrl.sv
// Tag-side Gen2 inventory sequencer: tag state, slot/Q ownership and reply scheduling.
// Optional sensor commands (Trans/SampleSensor/ReadSensor) are enabled by defining SENSOR_CMDS_EN.
module inventory_ctrl #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int unsigned SLOT_W = 15
) (
    input  logic              bitclk,
    input  logic              reset_n,
    input  logic [11:0]       cmd_in,
    input  logic              packet_complete,
    input  logic              crc_ok,
    input  logic [3:0]        q_in,
    input  logic              qadj_up,
    input  logic              qadj_dn,
    input  logic              rn_match,
    input  logic              tx_done,
    output logic [2:0]        state,
    output logic              tx_start,
    output logic [2:0]        tx_type,
    output logic              tx_busy,
    output logic [SLOT_W-1:0] slot,
    output logic [3:0]        q
);

    typedef enum logic [2:0] {
        ST_READY        = 3'd0,
        ST_ARBITRATE    = 3'd1,
        ST_REPLY        = 3'd2,
        ST_ACKNOWLEDGED = 3'd3,
        ST_OPEN         = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        TX_RN16   = 3'd0,
        TX_EPC    = 3'd1,
        TX_HANDLE = 3'd2,
        TX_DATA   = 3'd3,
        TX_SENSOR = 3'd4
    } tx_t;

`ifdef SENSOR_CMDS_EN
    localparam logic [11:0] LEGAL_CMDS = 12'hFFF;
`else
    localparam logic [11:0] LEGAL_CMDS = 12'h1FF;
`endif

    state_t            state_q, state_d;
    tx_t               tx_type_q, tx_type_d, launch_type;
    logic [SLOT_W-1:0] slot_q, slot_d, draw;
    logic [3:0]        q_q, q_d, q_adj, q_draw;
    logic              tx_start_q, tx_start_d;
    logic              tx_busy_q, tx_busy_d;
    logic              launch;
    logic [15:0]       lfsr_q;
    logic              pc_q;
    logic [14:0]       draw_mask;
    logic              cmd_valid, crc_exempt, accept;

    assign cmd_valid  = (cmd_in != '0) && ((cmd_in & (cmd_in - 12'd1)) == '0)
                        && ((cmd_in & ~LEGAL_CMDS) == '0);
    assign crc_exempt = cmd_in[0] | cmd_in[2] | cmd_in[3];
    assign accept     = packet_complete & ~pc_q & cmd_valid & (crc_ok | crc_exempt) & ~tx_busy_q;

    always_comb begin
        q_adj = q_q;
        if (qadj_up && !qadj_dn && q_q != 4'hF)
            q_adj = q_q + 4'd1;
        else if (qadj_dn && !qadj_up && q_q != 4'h0)
            q_adj = q_q - 4'd1;
    end

    // Draw uses the post-update Q; a shift of 15 yields 0 so the mask becomes all ones.
    assign q_draw    = cmd_in[2] ? q_in : q_adj;
    assign draw_mask = (15'd1 << q_draw) - 15'd1;
    assign draw      = SLOT_W'(lfsr_q[14:0] & draw_mask);

    always_ff @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_READY;
            slot_q     <= '0;
            q_q        <= '0;
            tx_start_q <= 1'b0;
            tx_type_q  <= TX_RN16;
            tx_busy_q  <= 1'b0;
            lfsr_q     <= SEED;
            pc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            q_q        <= q_d;
            tx_start_q <= tx_start_d;
            tx_type_q  <= tx_type_d;
            tx_busy_q  <= tx_busy_d;
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            pc_q       <= packet_complete;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        q_d         = q_q;
        tx_start_d  = 1'b0;
        tx_type_d   = tx_type_q;
        tx_busy_d   = tx_busy_q & ~tx_done;
        launch      = 1'b0;
        launch_type = TX_RN16;

        if (accept) begin
            if (cmd_in[2] || cmd_in[3]) begin
                if (cmd_in[2] || state_q == ST_ARBITRATE || state_q == ST_REPLY) begin
                    q_d    = q_draw;
                    slot_d = draw;
                    if (draw == '0) begin
                        state_d = ST_REPLY;
                        launch  = 1'b1;
                    end else begin
                        state_d = ST_ARBITRATE;
                    end
                end
            end else if (cmd_in[0]) begin
                case (state_q)
                    ST_ARBITRATE: begin
                        // Slot saturates at zero; reaching or sitting at zero both reply.
                        if (slot_q > SLOT_W'(1)) begin
                            slot_d = slot_q - SLOT_W'(1);
                        end else begin
                            slot_d  = '0;
                            state_d = ST_REPLY;
                            launch  = 1'b1;
                        end
                    end
                    ST_REPLY: begin
                        state_d = ST_ARBITRATE;
                        slot_d  = '1;
                    end
                    ST_ACKNOWLEDGED, ST_OPEN: state_d = ST_READY;
                    default: ;
                endcase
            end else if (cmd_in[1]) begin
                if (rn_match && (state_q == ST_REPLY || state_q == ST_ACKNOWLEDGED
                                 || state_q == ST_OPEN)) begin
                    if (state_q != ST_OPEN)
                        state_d = ST_ACKNOWLEDGED;
                    launch      = 1'b1;
                    launch_type = TX_EPC;
                end else if (state_q == ST_REPLY || state_q == ST_ACKNOWLEDGED) begin
                    state_d = ST_ARBITRATE;
                end
            end else if (cmd_in[4]) begin
                state_d = ST_READY;
                slot_d  = '0;
            end else if (cmd_in[5]) begin
                if (state_q != ST_READY)
                    state_d = ST_ARBITRATE;
            end else if (cmd_in[6]) begin
                if (rn_match && state_q == ST_ACKNOWLEDGED) begin
                    state_d     = ST_OPEN;
                    launch      = 1'b1;
                    launch_type = TX_HANDLE;
                end else if (rn_match && state_q == ST_OPEN) begin
                    launch      = 1'b1;
                    launch_type = TX_RN16;
                end
            end else if (cmd_in[7] || cmd_in[8]) begin
                if (rn_match && state_q == ST_OPEN) begin
                    launch      = 1'b1;
                    launch_type = TX_DATA;
                end
`ifdef SENSOR_CMDS_EN
            end else if (cmd_in[9] || cmd_in[10] || cmd_in[11]) begin
                if (rn_match && state_q == ST_OPEN) begin
                    launch      = 1'b1;
                    launch_type = TX_SENSOR;
                end
`endif
            end
        end

        if (launch) begin
            tx_start_d = 1'b1;
            tx_type_d  = launch_type;
            tx_busy_d  = 1'b1;
        end
    end

    assign state    = state_q;
    assign tx_start = tx_start_q;
    assign tx_type  = tx_type_q;
    assign tx_busy  = tx_busy_q;
    assign slot     = slot_q;
    assign q        = q_q;

endmodule

// File: tb/tb_inventory_ctrl.sv
// Directed bench for inventory_ctrl; honours SENSOR_CMDS_EN the same way the design does.
module tb_inventory_ctrl;

    localparam logic [11:0] C_QREP   = 12'h001;
    localparam logic [11:0] C_ACK    = 12'h002;
    localparam logic [11:0] C_QUERY  = 12'h004;
    localparam logic [11:0] C_QADJ   = 12'h008;
    localparam logic [11:0] C_SELECT = 12'h010;
    localparam logic [11:0] C_NACK   = 12'h020;
    localparam logic [11:0] C_REQRN  = 12'h040;
    localparam logic [11:0] C_READ   = 12'h080;
    localparam logic [11:0] C_SAMPLE = 12'h400;

    logic        bitclk = 1'b0;
    logic        reset_n;
    logic [11:0] cmd_in;
    logic        packet_complete, crc_ok, qadj_up, qadj_dn, rn_match, tx_done;
    logic [3:0]  q_in;
    logic [2:0]  state, tx_type;
    logic        tx_start, tx_busy;
    logic [14:0] slot;
    logic [3:0]  q;

    logic [15:0] lfsr_m;
    logic [15:0] ev_lfsr;
    logic [14:0] e_slot;
    int          n_checks = 0;
    int          n_errors = 0;

    inventory_ctrl #(.SEED(16'hACE1), .SLOT_W(15)) dut (
        .bitclk(bitclk), .reset_n(reset_n), .cmd_in(cmd_in),
        .packet_complete(packet_complete), .crc_ok(crc_ok), .q_in(q_in),
        .qadj_up(qadj_up), .qadj_dn(qadj_dn), .rn_match(rn_match), .tx_done(tx_done),
        .state(state), .tx_start(tx_start), .tx_type(tx_type), .tx_busy(tx_busy),
        .slot(slot), .q(q)
    );

    always #5 bitclk = ~bitclk;

    // Reference LFSR x^16+x^14+x^13+x^11+1, stepping every clock from the seed
    always @(posedge bitclk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 16'hACE1;
        else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] draw_of(input logic [15:0] l, input logic [3:0] qv);
        logic [14:0] m;
        m = '0;
        for (int i = 0; i < 15; i++)
            if (i < int'(qv)) m[i] = 1'b1;
        return l[14:0] & m;
    endfunction

    // One packet: a low gap, optional wait for an LFSR nibble, then a rising packet_complete.
    task automatic send(input logic [11:0] cmd, input bit crc, input bit match,
                        input bit done, input int nib);
        bit timed_out;
        int guard;
        @(negedge bitclk);
        packet_complete = 1'b0;
        tx_done = 1'b0;
        @(negedge bitclk);
        if (nib >= 0) begin
            timed_out = 1'b0;
            guard = 0;
            while (lfsr_m[3:0] != 4'(nib) && !timed_out) begin
                @(negedge bitclk);
                guard++;
                if (guard > 500) timed_out = 1'b1;
            end
            check("lfsr_wait", 32'(timed_out), 32'd0);
        end
        cmd_in = cmd;
        crc_ok = crc;
        rn_match = match;
        tx_done = done;
        packet_complete = 1'b1;
        ev_lfsr = lfsr_m;
        @(posedge bitclk);
        #1;
        tx_done = 1'b0;
    endtask

    task automatic finish_tx;
        @(negedge bitclk);
        tx_done = 1'b1;
        @(negedge bitclk);
        tx_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        cmd_in = '0; packet_complete = 1'b0; crc_ok = 1'b0; q_in = '0;
        qadj_up = 1'b0; qadj_dn = 1'b0; rn_match = 1'b0; tx_done = 1'b0;
        #23;
        check("rst_state", 32'(state), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_type", 32'(tx_type), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        @(negedge bitclk);
        reset_n = 1'b1;

        // Query q=0 always draws 0; no CRC needed
        q_in = 4'd0;
        send(C_QUERY, 1'b0, 1'b0, 1'b0, -1);
        check("q0_state", 32'(state), 32'd2);
        check("q0_start", 32'(tx_start), 32'd1);
        check("q0_type", 32'(tx_type), 32'd0);
        check("q0_slot", 32'(slot), 32'd0);
        check("q0_busy", 32'(tx_busy), 32'd1);
        @(posedge bitclk); #1;
        check("q0_pulse", 32'(tx_start), 32'd0);
        check("q0_busy_hold", 32'(tx_busy), 32'd1);
        finish_tx();
        check("q0_busy_fall", 32'(tx_busy), 32'd0);

        // Query q=4 timed so the draw is 3, then count down
        q_in = 4'd4;
        send(C_QUERY, 1'b0, 1'b0, 1'b0, 3);
        check("q4_state", 32'(state), 32'd1);
        check("q4_slot", 32'(slot), 32'd3);
        check("q4_q", 32'(q), 32'd4);
        check("q4_start", 32'(tx_start), 32'd0);
        send(C_QREP, 1'b0, 1'b0, 1'b0, -1);
        check("rep1_slot", 32'(slot), 32'd2);
        check("rep1_state", 32'(state), 32'd1);
        send(C_QREP, 1'b0, 1'b0, 1'b0, -1);
        check("rep2_slot", 32'(slot), 32'd1);
        send(C_QREP, 1'b0, 1'b0, 1'b0, -1);
        check("rep3_slot", 32'(slot), 32'd0);
        check("rep3_state", 32'(state), 32'd2);
        check("rep3_start", 32'(tx_start), 32'd1);
        check("rep3_type", 32'(tx_type), 32'd0);
        finish_tx();

        // Ack -> ACKNOWLEDGED, then events dropped while busy
        send(C_ACK, 1'b1, 1'b1, 1'b0, -1);
        check("ack_state", 32'(state), 32'd3);
        check("ack_type", 32'(tx_type), 32'd1);
        check("ack_start", 32'(tx_start), 32'd1);
        send(C_REQRN, 1'b1, 1'b1, 1'b0, -1);
        check("busy_drop_state", 32'(state), 32'd3);
        check("busy_drop_start", 32'(tx_start), 32'd0);
        check("busy_drop_slot", 32'(slot), 32'd0);
        check("busy_drop_busy", 32'(tx_busy), 32'd1);
        send(C_REQRN, 1'b1, 1'b1, 1'b1, -1);
        check("done_drop_state", 32'(state), 32'd3);
        check("done_drop_start", 32'(tx_start), 32'd0);
        check("done_drop_busy", 32'(tx_busy), 32'd0);
        check("done_drop_type", 32'(tx_type), 32'd1);
        send(C_REQRN, 1'b1, 1'b1, 1'b0, -1);
        check("reqrn_state", 32'(state), 32'd4);
        check("reqrn_type", 32'(tx_type), 32'd2);
        check("reqrn_start", 32'(tx_start), 32'd1);
        finish_tx();
        send(C_READ, 1'b0, 1'b1, 1'b0, -1);
        check("rd_badcrc_start", 32'(tx_start), 32'd0);
        check("rd_badcrc_state", 32'(state), 32'd4);
        check("rd_badcrc_busy", 32'(tx_busy), 32'd0);
        send(C_READ, 1'b1, 1'b1, 1'b0, -1);
        check("rd_start", 32'(tx_start), 32'd1);
        check("rd_type", 32'(tx_type), 32'd3);
        finish_tx();

        // Q saturation at 15 with redraw
        q_in = 4'd15;
        send(C_QUERY, 1'b0, 1'b0, 1'b0, -1);
        e_slot = draw_of(ev_lfsr, 4'd15);
        check("q15_q", 32'(q), 32'd15);
        check("q15_slot", 32'(slot), 32'(e_slot));
        check("q15_state", 32'(state), (e_slot == '0) ? 32'd2 : 32'd1);
        if (e_slot == '0) finish_tx();
        qadj_up = 1'b1; qadj_dn = 1'b0;
        send(C_QADJ, 1'b0, 1'b0, 1'b0, -1);
        e_slot = draw_of(ev_lfsr, 4'd15);
        check("adjup_q", 32'(q), 32'd15);
        check("adjup_slot", 32'(slot), 32'(e_slot));
        check("adjup_state", 32'(state), (e_slot == '0) ? 32'd2 : 32'd1);
        if (e_slot == '0) finish_tx();

        // Q saturation at 0
        q_in = 4'd0;
        send(C_QUERY, 1'b0, 1'b0, 1'b0, -1);
        finish_tx();
        qadj_up = 1'b0; qadj_dn = 1'b1;
        send(C_QADJ, 1'b0, 1'b0, 1'b0, -1);
        check("adjdn_q", 32'(q), 32'd0);
        check("adjdn_state", 32'(state), 32'd2);
        check("adjdn_start", 32'(tx_start), 32'd1);
        finish_tx();
        qadj_dn = 1'b0;

        // Nack, QueryRep at slot 0, QueryRep in REPLY, Select, illegal two-hot
        send(C_NACK, 1'b1, 1'b0, 1'b0, -1);
        check("nack_state", 32'(state), 32'd1);
        check("nack_start", 32'(tx_start), 32'd0);
        send(C_QREP, 1'b0, 1'b0, 1'b0, -1);
        check("rep0_state", 32'(state), 32'd2);
        check("rep0_slot", 32'(slot), 32'd0);
        check("rep0_start", 32'(tx_start), 32'd1);
        finish_tx();
        send(C_QREP, 1'b0, 1'b0, 1'b0, -1);
        check("repr_state", 32'(state), 32'd1);
        check("repr_slot", 32'(slot), 32'h7FFF);
        check("repr_start", 32'(tx_start), 32'd0);
        send(C_SELECT, 1'b1, 1'b0, 1'b0, -1);
        check("sel_state", 32'(state), 32'd0);
        check("sel_slot", 32'(slot), 32'd0);
        send(C_QUERY | C_QREP, 1'b1, 1'b0, 1'b0, -1);
        check("illegal_state", 32'(state), 32'd0);
        check("illegal_start", 32'(tx_start), 32'd0);

        // Reach OPEN with q=1 (draw 0 needs lfsr[0]=0), then sensor command
        q_in = 4'd1;
        send(C_QUERY, 1'b0, 1'b0, 1'b0, 2);
        check("q1_state", 32'(state), 32'd2);
        check("q1_q", 32'(q), 32'd1);
        finish_tx();
        send(C_ACK, 1'b1, 1'b1, 1'b0, -1);
        finish_tx();
        send(C_REQRN, 1'b1, 1'b1, 1'b0, -1);
        check("open_state", 32'(state), 32'd4);
        finish_tx();
        send(C_SAMPLE, 1'b1, 1'b1, 1'b0, -1);
`ifdef SENSOR_CMDS_EN
        check("sensor_start", 32'(tx_start), 32'd1);
        check("sensor_type", 32'(tx_type), 32'd4);
`else
        check("sensor_start", 32'(tx_start), 32'd0);
        check("sensor_type", 32'(tx_type), 32'd2);
        send(C_READ, 1'b1, 1'b1, 1'b0, -1);
        check("rd2_type", 32'(tx_type), 32'd3);
`endif
        check("sensor_state", 32'(state), 32'd4);
        check("mid_busy", 32'(tx_busy), 32'd1);

        // Asynchronous reset mid-transmission, sampled between clock edges
        @(negedge bitclk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_q", 32'(q), 32'd0);
        check("arst_slot", 32'(slot), 32'd0);
        check("arst_start", 32'(tx_start), 32'd0);
        check("arst_type", 32'(tx_type), 32'd0);
        check("arst_busy", 32'(tx_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
